// File: rtl/clock_monitor.sv
// clock_monitor: measures a toggle-divided clock against clkIn over a fixed
// gate window and sequences DCM reset retries.
// Build option: define CLOCK_MONITOR_UNLOCK_CNT_EN to count locked_in drops
// on unlock_cnt; otherwise unlock_cnt is tied to 0.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | monitoring disabled, waiting for enable
// S_WAIT_LOCK | waiting for DCM lock, 4*WINDOW cycle timeout
// S_MEASURE   | counting tgl_in edges for WINDOW cycles
// S_CHECK     | one cycle: publish count, compare against EXP_LO..EXP_HI
// S_RESET_REQ | dcm_rst held high for RST_PULSE cycles
// S_FAIL      | retries exhausted, sticky until clear
`timescale 1ns/1ps

module clock_monitor #(
   parameter int WINDOW    = 1024,
   parameter int EXP_LO    = 500,
   parameter int EXP_HI    = 524,
   parameter int RETRY_MAX = 3,
   parameter int RST_PULSE = 8
) (
   input  logic        clkIn,
   input  logic        rst,
   input  logic        enable,
   input  logic        tgl_in,
   input  logic        locked_in,
   input  logic        clear,
   output logic        dcm_rst,
   output logic        freq_ok,
   output logic [15:0] count,
   output logic        count_valid,
   output logic        fail,
   output logic [7:0]  unlock_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LOCK,
      S_MEASURE,
      S_CHECK,
      S_RESET_REQ,
      S_FAIL
   } state_t;

   // One shared down-counter; 18 bits covers 4*65535-1.
   localparam logic [17:0] WAIT_LOAD  = 18'(4 * WINDOW - 1);
   localparam logic [17:0] MEAS_LOAD  = 18'(WINDOW - 1);
   localparam logic [17:0] PULSE_LOAD = 18'(RST_PULSE - 1);
   localparam logic [15:0] CNT_LO     = 16'(EXP_LO);
   localparam logic [15:0] CNT_HI     = 16'(EXP_HI);
   localparam logic [3:0]  RETRY_LIM  = 4'(RETRY_MAX);

   state_t      state, state_nxt;
   logic [17:0] tmr, tmr_nxt;
   logic        cnt_clr;
   logic [15:0] edge_cnt;
   logic [3:0]  retry;
   logic        tgl_s1, tgl_s2, tgl_s3;
   logic        lck_s1, lck_s2;
   logic        edge_det;
   logic        locked;
   logic        in_range;

   // Synchronize the asynchronous inputs; third tgl flop gives the edge history.
   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         tgl_s1 <= 1'b0;
         tgl_s2 <= 1'b0;
         tgl_s3 <= 1'b0;
         lck_s1 <= 1'b0;
         lck_s2 <= 1'b0;
      end else begin
         tgl_s1 <= tgl_in;
         tgl_s2 <= tgl_s1;
         tgl_s3 <= tgl_s2;
         lck_s1 <= locked_in;
         lck_s2 <= lck_s1;
      end
   end

   assign edge_det = tgl_s2 ^ tgl_s3;
   assign locked   = lck_s2;
   assign in_range = (edge_cnt >= CNT_LO) && (edge_cnt <= CNT_HI);

   // Next-state, timer reload and counter-clear decode.
   always_comb begin
      state_nxt = state;
      tmr_nxt   = (tmr != 18'd0) ? tmr - 18'd1 : 18'd0;
      cnt_clr   = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable) begin
               state_nxt = S_WAIT_LOCK;
               tmr_nxt   = WAIT_LOAD;
            end
         end
         S_WAIT_LOCK: begin
            if (!enable) begin
               state_nxt = S_IDLE;
            end else if (locked) begin
               state_nxt = S_MEASURE;
               tmr_nxt   = MEAS_LOAD;
               cnt_clr   = 1'b1;
            end else if (tmr == 18'd0) begin
               state_nxt = S_RESET_REQ;
               tmr_nxt   = PULSE_LOAD;
            end
         end
         S_MEASURE: begin
            if (!enable) begin
               state_nxt = S_IDLE;
            end else if (!locked) begin
               state_nxt = S_RESET_REQ;
               tmr_nxt   = PULSE_LOAD;
            end else if (tmr == 18'd0) begin
               state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (!enable) begin
               state_nxt = S_IDLE;
            end else if (in_range) begin
               state_nxt = S_MEASURE;
               tmr_nxt   = MEAS_LOAD;
               cnt_clr   = 1'b1;
            end else begin
               state_nxt = S_RESET_REQ;
               tmr_nxt   = PULSE_LOAD;
            end
         end
         S_RESET_REQ: begin
            if (!enable) begin
               state_nxt = S_IDLE;
            end else if (tmr == 18'd0) begin
               if (retry >= RETRY_LIM) begin
                  // A clear landing on the exhaustion cycle suppresses FAIL.
                  state_nxt = clear ? S_IDLE : S_FAIL;
               end else begin
                  state_nxt = S_WAIT_LOCK;
                  tmr_nxt   = WAIT_LOAD;
               end
            end
         end
         S_FAIL: begin
            if (clear) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and shared timer registers.
   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         tmr   <= 18'd0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
      end
   end

   // Saturating edge counter, live only while measuring.
   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         edge_cnt <= 16'd0;
      end else if (cnt_clr) begin
         edge_cnt <= 16'd0;
      end else if (state == S_MEASURE && edge_det && edge_cnt != 16'hFFFF) begin
         edge_cnt <= edge_cnt + 16'd1;
      end
   end

   // Retry count: bumps on each RESET_REQ entry, clears on a good window.
   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         retry <= 4'd0;
      end else if (clear) begin
         retry <= 4'd0;
      end else if (state == S_CHECK && state_nxt == S_MEASURE) begin
         retry <= 4'd0;
      end else if (state_nxt == S_RESET_REQ && state != S_RESET_REQ && retry != 4'hF) begin
         retry <= retry + 4'd1;
      end
   end

   // Registered outputs derived from the upcoming state.
   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         dcm_rst     <= 1'b0;
         fail        <= 1'b0;
         freq_ok     <= 1'b0;
         count       <= 16'd0;
         count_valid <= 1'b0;
      end else begin
         dcm_rst     <= (state_nxt == S_RESET_REQ);
         fail        <= (state_nxt == S_FAIL);
         count_valid <= (state == S_CHECK) && enable;
         if (state == S_CHECK && enable) begin
            count <= edge_cnt;
         end
         if (state == S_CHECK && state_nxt == S_MEASURE) begin
            freq_ok <= 1'b1;
         end else if (state_nxt != S_MEASURE && state_nxt != S_CHECK) begin
            freq_ok <= 1'b0;
         end
      end
   end

`ifdef CLOCK_MONITOR_UNLOCK_CNT_EN
   logic lck_s3;

   // Count synchronized locked_in falling edges, saturating at 255.
   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         lck_s3     <= 1'b0;
         unlock_cnt <= 8'd0;
      end else begin
         lck_s3 <= lck_s2;
         if (clear) begin
            unlock_cnt <= 8'd0;
         end else if (lck_s3 && !lck_s2 && unlock_cnt != 8'hFF) begin
            unlock_cnt <= unlock_cnt + 8'd1;
         end
      end
   end
`else
   assign unlock_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor with default parameters (WINDOW=1024, 500..524,
// 3 retries, 8-cycle dcm_rst pulse). tgl_in comes from a rate generator that
// produces 'rate' toggles per 1024 cycles, so each window should hold rate+-1.
`timescale 1ns/1ps

module tb_clock_monitor;

   logic        clkIn;
   logic        rst;
   logic        enable;
   logic        tgl_in;
   logic        locked_in;
   logic        clear;
   logic        dcm_rst;
   logic        freq_ok;
   logic [15:0] count;
   logic        count_valid;
   logic        fail;
   logic [7:0]  unlock_cnt;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int rate     = 512;
   int acc      = 0;
   int exp_unl  = 0;
   int cv_total = 0;
   int dcm_hi   = 0;
   int cur_w    = 0;
   bit dcm_prev = 1'b0;
   int width_q[$];
   int rise_q[$];

   clock_monitor dut (
      .clkIn      (clkIn),
      .rst        (rst),
      .enable     (enable),
      .tgl_in     (tgl_in),
      .locked_in  (locked_in),
      .clear      (clear),
      .dcm_rst    (dcm_rst),
      .freq_ok    (freq_ok),
      .count      (count),
      .count_valid(count_valid),
      .fail       (fail),
      .unlock_cnt (unlock_cnt)
   );

   initial begin
      clkIn = 1'b0;
      forever #5 clkIn = ~clkIn;
   end

   always @(posedge clkIn) cyc++;

   // Monitored clock: rate toggles per 1024 cycles, evenly spread.
   initial begin
      tgl_in = 1'b0;
      forever begin
         @(posedge clkIn);
         #2;
         acc += rate;
         if (acc >= 1024) begin
            acc -= 1024;
            tgl_in = ~tgl_in;
         end
      end
   end

   // Record dcm_rst pulse widths / rise cycles and count strobes.
   always @(negedge clkIn) begin
      if (dcm_rst && !dcm_prev) begin
         rise_q.push_back(cyc);
         cur_w = 1;
      end else if (dcm_rst) begin
         cur_w++;
      end
      if (!dcm_rst && dcm_prev) width_q.push_back(cur_w);
      dcm_prev = dcm_rst;
      if (count_valid) cv_total++;
      if (dcm_rst) dcm_hi++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int exp_unlock();
`ifdef CLOCK_MONITOR_UNLOCK_CNT_EN
      return (exp_unl > 255) ? 255 : exp_unl;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
      n_checks++;
      assert (!$isunknown(obs) && obs >= lo && obs <= hi) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clkIn);
         #1;
      end
   endtask

   // sel: 0 count_valid, 1 dcm_rst, 2 fail
   task automatic wait_ev(input int sel, input int bound, output bit got, output int n);
      got = 1'b0;
      n   = 0;
      while (!got && n < bound) begin
         @(posedge clkIn);
         #1;
         n++;
         case (sel)
            0:       got = (count_valid === 1'b1);
            1:       got = (dcm_rst === 1'b1);
            default: got = (fail === 1'b1);
         endcase
      end
   endtask

   initial begin
      bit got;
      int n;
      int r;
      int cv0;
      int n_unl;

      rst = 1'b1; enable = 1'b0; clear = 1'b0; locked_in = 1'b0;
      step(3);
      chk("rst_dcm_rst", dcm_rst, 0);
      chk("rst_freq_ok", freq_ok, 0);
      chk("rst_count", count, 0);
      chk("rst_count_valid", count_valid, 0);
      chk("rst_fail", fail, 0);
      chk("rst_unlock_cnt", unlock_cnt, 0);
      rst = 1'b0;

      // Nominal lock at 512 edges per window.
      locked_in = 1'b1;
      step(4);
      enable = 1'b1;
      wait_ev(0, 1200, got, n);
      chk("nom_first_seen", got, 1);
      chk("nom_first_latency", n, 1027);
      chk_rng("nom_count0", count, 511, 513);
      chk("nom_freq_ok0", freq_ok, 1);
      for (int k = 0; k < 2; k++) begin
         wait_ev(0, 1100, got, n);
         chk("nom_interval", n, 1025);
         chk_rng("nom_count", count, 511, 513);
         chk("nom_freq_ok", freq_ok, 1);
      end

      // Random in-range rates; first window after a change is mixed, skip it.
      for (int k = 0; k < 3; k++) begin
         r = $urandom_range(505, 519);
         rate = r;
         wait_ev(0, 1100, got, n);
         wait_ev(0, 1100, got, n);
         chk("rnd_interval", n, 1025);
         chk_rng("rnd_count", count, r - 1, r + 1);
         chk("rnd_freq_ok", freq_ok, 1);
      end
      chk("nom_no_dcm_rst", dcm_hi, 0);

      // Slow clock: three failing windows lead to FAIL.
      width_q.delete();
      rise_q.delete();
      r = $urandom_range(300, 480);
      rate = r;
      wait_ev(0, 1100, got, n);
      chk("slow_seen", got, 1);
      chk_rng("slow_count", count, r - 3, r + 3);
      chk("slow_freq_ok", freq_ok, 0);
      wait_ev(2, 6000, got, n);
      chk("slow_fail_seen", got, 1);
      step(2);
      chk("slow_pulse_cnt", width_q.size(), 3);
      foreach (width_q[i]) chk("slow_pulse_w", width_q[i], 8);
      cv0 = cv_total;
      step(200);
      chk("fail_sticky", fail, 1);
      chk("fail_dcm_low", dcm_rst, 0);
      chk("fail_no_valid", cv_total, cv0);
      rate = 512;
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      chk("clear_fail", fail, 0);
      wait_ev(0, 1200, got, n);
      chk("clear_restart_latency", n, 1027);
      chk("clear_restart_ok", freq_ok, 1);

      // Unlock 300 cycles into a window, then abort in pulse cycle 3.
      wait_ev(0, 1100, got, n);
      width_q.delete();
      step(299);
      cv0 = cv_total;
      locked_in = 1'b0;
      exp_unl++;
      wait_ev(1, 10, got, n);
      chk("unl_dcm_seen", got, 1);
      chk_rng("unl_dcm_latency", n, 1, 4);
      chk("unl_no_valid", cv_total, cv0);
      chk("unl_unlock_cnt", unlock_cnt, exp_unlock());
      step(2);
      enable = 1'b0;
      step(1);
      chk("abort_dcm_rst", dcm_rst, 0);
      chk("abort_freq_ok", freq_ok, 0);
      step(2);
      chk("abort_pulse_cnt", width_q.size(), 1);
      foreach (width_q[i]) chk("abort_pulse_w", width_q[i], 3);

      // Restore a good window so the retry count starts from zero.
      locked_in = 1'b1;
      step(5);
      enable = 1'b1;
      wait_ev(0, 1200, got, n);
      wait_ev(0, 1100, got, n);
      chk("restore_freq_ok", freq_ok, 1);
      enable = 1'b0;
      step(3);

      // No lock: 4096-cycle timeout, three pulses, then FAIL.
      locked_in = 1'b0;
      exp_unl++;
      step(5);
      width_q.delete();
      rise_q.delete();
      enable = 1'b1;
      wait_ev(1, 4200, got, n);
      chk("nolock_dcm_seen", got, 1);
      chk_rng("nolock_timeout", n, 4095, 4099);
      wait_ev(2, 9000, got, n);
      chk("nolock_fail_seen", got, 1);
      step(2);
      chk("nolock_pulse_cnt", width_q.size(), 3);
      foreach (width_q[i]) chk("nolock_pulse_w", width_q[i], 8);
      for (int i = 1; i < rise_q.size(); i++) chk("nolock_retry_gap", rise_q[i] - rise_q[i-1], 4104);
      chk("nolock_unlock_cnt", unlock_cnt, exp_unlock());
      locked_in = 1'b1;
      step(3);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      exp_unl = 0;
      chk("nolock_clear_fail", fail, 0);
      chk("nolock_clear_unl", unlock_cnt, exp_unlock());

      // Asynchronous reset in the middle of a window.
      wait_ev(0, 1300, got, n);
      chk("prerst_freq_ok", freq_ok, 1);
      step(200);
      #2;
      rst = 1'b1;
      #1;
      exp_unl = 0;
      chk("arst_dcm_rst", dcm_rst, 0);
      chk("arst_freq_ok", freq_ok, 0);
      chk("arst_count", count, 0);
      chk("arst_count_valid", count_valid, 0);
      chk("arst_fail", fail, 0);
      chk("arst_unlock_cnt", unlock_cnt, 0);
      @(posedge clkIn);
      #1;
      enable = 1'b0;
      rst = 1'b0;
      step(3);

      // Unlock counter saturation (or constant zero without the option).
`ifdef CLOCK_MONITOR_UNLOCK_CNT_EN
      n_unl = 300;
`else
      n_unl = 5;
`endif
      for (int i = 0; i < n_unl; i++) begin
         locked_in = 1'b0;
         exp_unl++;
         step(4);
         locked_in = 1'b1;
         step(4);
      end
      step(4);
      chk("sat_unlock_cnt", unlock_cnt, exp_unlock());
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      exp_unl = 0;
      chk("sat_clear_unl", unlock_cnt, exp_unlock());

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 Parameter WINDOW, default 1024: gate length in clkIn cycles per measurement, range 16..65535.
REQ-002 Parameter EXP_LO, default 500: minimum acceptable edge count per window.
REQ-003 Parameter EXP_HI, default 524: maximum acceptable edge count per window.
REQ-004 Parameter RETRY_MAX, default 3: number of dcm_rst attempts allowed before FAIL, range 1..15.
REQ-005 Parameter RST_PULSE, default 8: dcm_rst pulse width in clkIn cycles, range 3..255.
REQ-006 Port clkIn, input, 1: sole clock, the reference clock; one clock, reset is asynchronous and active-high.
REQ-007 Port rst, input, 1: asynchronous active-high reset.
REQ-008 Port enable, input, 1: high starts and continues monitoring; low returns the FSM to IDLE.
REQ-009 Port tgl_in, input, 1: toggle-divided monitored clock, asynchronous to clkIn.
REQ-010 Port locked_in, input, 1: DCM locked status, asynchronous.
REQ-011 Port clear, input, 1: single-cycle pulse that clears FAIL, the retry count and unlock_cnt.
REQ-012 Port dcm_rst, output, 1: active-high DCM reset request.
REQ-013 Port freq_ok, output, 1: high when the last completed window was in range.
REQ-014 Port count, output, 16: edge count of the last completed window.
REQ-015 Port count_valid, output, 1: one-cycle strobe when count updates.
REQ-016 Port fail, output, 1: sticky failure flag.
REQ-017 Port unlock_cnt, output, 8: count of locked_in falling edges.

Function
REQ-018 tgl_in and locked_in each pass through a two-flop synchronizer. A third flop on tgl_in feeds the edge detector.
REQ-019 Any change of synchronized tgl_in counts as one edge. The edge counter is 16 bits and saturates at 65535.
REQ-020 FSM states are IDLE, WAIT_LOCK, MEASURE, CHECK, RESET_REQ and FAIL.
REQ-021 IDLE: go to WAIT_LOCK when enable=1.
REQ-022 WAIT_LOCK: go to MEASURE when synchronized locked=1. If locked stays 0 for 4*WINDOW cycles, go to RESET_REQ.
REQ-023 MEASURE: clear the edge counter on entry and run exactly WINDOW cycles, then go to CHECK. If locked falls during MEASURE, go to RESET_REQ immediately and discard the window.
REQ-024 CHECK: lasts one cycle.
  - count is loaded and count_valid pulses.
  - freq_ok = (EXP_LO <= count <= EXP_HI).
  - If in range: retry count clears and the FSM returns to MEASURE.
  - If out of range: go to RESET_REQ.
REQ-025 RESET_REQ: dcm_rst is high for exactly RST_PULSE cycles and the retry count increments. Next state is WAIT_LOCK, or FAIL if the retry count has reached RETRY_MAX.
REQ-026 FAIL: fail=1 and dcm_rst=0. The FSM stays in FAIL until clear=1, then goes to IDLE.
REQ-027 enable=0 in any state except FAIL:
  - FSM goes to IDLE next cycle.
  - dcm_rst deasserts next cycle, even mid-pulse.
  - freq_ok clears.
REQ-028 freq_ok clears on entry to RESET_REQ and WAIT_LOCK.
REQ-029 When clear and an event that sets the flags occur in the same cycle, clear wins.
REQ-030 All outputs are registered.

Reset
REQ-031 While rst=1:
  - FSM is IDLE.
  - dcm_rst=0, freq_ok=0, count=0, count_valid=0, fail=0, unlock_cnt=0.
  - Synchronizers, counters and retry count are 0.
REQ-032 Reset deassertion needs no synchronization internal to this block; the integrator synchronizes the release.

Configuration
REQ-033 Macro CLOCK_MONITOR_UNLOCK_CNT_EN controls unlock counting.
  - Defined: unlock_cnt increments on each synchronized locked_in falling edge, saturates at 255, and clears on clear.
  - Undefined: unlock_cnt is constant 0 and its counter logic is not generated.

Verification
REQ-034 Scenario, nominal lock: locked_in=1, tgl_in at 512 edges per 1024 cycles, enable=1 -> count_valid every 1025 cycles, count=512±1, freq_ok=1, dcm_rst never asserted.
REQ-035 Scenario, slow clock: 400 edges per window -> freq_ok=0 and an 8-cycle dcm_rst pulse. Persisting 3 times -> fail=1. A clear pulse -> fail=0 and FSM in IDLE.
REQ-036 Scenario, unlock mid-window: locked_in falls 300 cycles into MEASURE -> no count_valid for that window, dcm_rst within 4 cycles. With the macro defined, unlock_cnt=1.
REQ-037 Scenario, no lock: locked_in held 0 -> dcm_rst asserted 4096 cycles after enable, then repeated until fail=1 after the third pulse.
REQ-038 Scenario, abort and reset: enable dropped in cycle 3 of a dcm_rst pulse -> dcm_rst=0 the next cycle. Separately, rst asserted mid-MEASURE -> all outputs 0 asynchronously.
REQ-039 Scenario, saturation: a build without the macro shows unlock_cnt=0 after 5 unlocks. A build with the macro shows unlock_cnt=255 after 300 unlocks.
